// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction-type codes, sequencer state encoding
// and source-register usage helpers for the decoder, forwarding and hazard logic.
package pipe_pkg;

   localparam logic [2:0] TYPE_I_LOAD  = 3'b000;
   localparam logic [2:0] TYPE_I_LOGIC = 3'b001;
   localparam logic [2:0] TYPE_S       = 3'b010;
   localparam logic [2:0] TYPE_R       = 3'b011;
   localparam logic [2:0] TYPE_J       = 3'b100;
   localparam logic [2:0] TYPE_U       = 3'b101;
   localparam logic [2:0] TYPE_I_JUMP  = 3'b110;
   localparam logic [2:0] TYPE_B       = 3'b111;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_FLUSH    = 2'd2;

   function automatic logic uses_r1(input logic [2:0] itype);
      return (itype != TYPE_J) && (itype != TYPE_U);
   endfunction

   function automatic logic uses_r2(input logic [2:0] itype);
      return (itype == TYPE_R) || (itype == TYPE_S) || (itype == TYPE_B);
   endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter with enable and synchronous clear that sticks at 16'hFFFF.
module sat_counter16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clr,
   output logic [15:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != '1))
         count <= count + 16'd1;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/enable/flush sequencing for the 5-stage pipeline: load-use stalls,
// EX redirects with a bubble tail, data-memory freezes and perf counters.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned REDIRECT_BUBBLES = 1,
   parameter int unsigned MEM_TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  IF_ID_type,
   input  logic [4:0]  IF_ID_r1,
   input  logic [4:0]  IF_ID_r2,
   input  logic [2:0]  ID_EX_type,
   input  logic [4:0]  ID_EX_rd,
   input  logic        ex_redirect,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        IF_ID_en,
   output logic        ID_EX_en,
   output logic        EX_MEM_en,
   output logic        IF_ID_flush,
   output logic        ID_EX_flush,
   output logic        MEM_WB_flush,
   output logic        mem_timeout,
   output logic [15:0] stall_cycles,
   output logic [15:0] redirect_count
);

   localparam logic [2:0]  BUBBLES    = 3'(REDIRECT_BUBBLES);
   localparam logic [15:0] TIMEOUT_M1 = 16'(MEM_TIMEOUT - 1);

   logic [1:0]  state, state_nxt;
   logic [2:0]  bcnt, bcnt_nxt;
   logic        mem_busy, load_use, redirect_take;
   logic [15:0] wait_cnt;

   assign mem_busy = dmem_req && !dmem_ready;
   assign load_use = (ID_EX_type == TYPE_I_LOAD) && (ID_EX_rd != '0) &&
                     ((uses_r1(IF_ID_type) && (IF_ID_r1 == ID_EX_rd)) ||
                      (uses_r2(IF_ID_type) && (IF_ID_r2 == ID_EX_rd)));

   // FLUSH is tested before the redirect because a redirect is only honoured
   // outside FLUSH; the resulting priority is unchanged.
   always_comb begin
      pc_en         = 1'b1;
      IF_ID_en      = 1'b1;
      ID_EX_en      = 1'b1;
      EX_MEM_en     = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      MEM_WB_flush  = 1'b0;
      state_nxt     = ST_RUN;
      bcnt_nxt      = bcnt;
      redirect_take = 1'b0;
      if (rst) begin
         pc_en        = 1'b0;
         IF_ID_en     = 1'b0;
         ID_EX_en     = 1'b0;
         EX_MEM_en    = 1'b0;
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
         MEM_WB_flush = 1'b1;
         bcnt_nxt     = '0;
      end else if (mem_busy) begin
         pc_en        = 1'b0;
         IF_ID_en     = 1'b0;
         ID_EX_en     = 1'b0;
         EX_MEM_en    = 1'b0;
         MEM_WB_flush = 1'b1;
         state_nxt    = (state == ST_FLUSH) ? ST_FLUSH : ST_MEM_WAIT;
      end else if (state == ST_FLUSH) begin
         IF_ID_flush = 1'b1;
         bcnt_nxt    = bcnt - 3'd1;
         state_nxt   = (bcnt == 3'd1) ? ST_RUN : ST_FLUSH;
      end else if (ex_redirect) begin
         IF_ID_flush   = 1'b1;
         ID_EX_flush   = 1'b1;
         redirect_take = 1'b1;
         if (REDIRECT_BUBBLES != 0) begin
            state_nxt = ST_FLUSH;
            bcnt_nxt  = BUBBLES;
         end
      end else if (load_use) begin
         pc_en       = 1'b0;
         IF_ID_en    = 1'b0;
         ID_EX_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   // Set on the edge that completes the MEM_TIMEOUT-th consecutive busy cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mem_timeout <= 1'b0;
      else if (mem_busy && (wait_cnt == TIMEOUT_M1))
         mem_timeout <= 1'b1;
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (!pc_en),
      .clr   (1'b0),
      .count (stall_cycles)
   );

   sat_counter16 u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (redirect_take),
      .clr   (1'b0),
      .count (redirect_count)
   );

   sat_counter16 u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (mem_busy),
      .clr   (!mem_busy),
      .count (wait_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: two parameterisations share the
// same inputs and are compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned RB0 = 1;
   localparam int unsigned TO0 = 4;
   localparam int unsigned RB1 = 3;
   localparam int unsigned TO1 = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  IF_ID_type;
   logic [4:0]  IF_ID_r1, IF_ID_r2;
   logic [2:0]  ID_EX_type;
   logic [4:0]  ID_EX_rd;
   logic        ex_redirect, dmem_req, dmem_ready;

   logic [1:0]  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en;
   logic [1:0]  IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout;
   logic [15:0] stall_cycles [2];
   logic [15:0] redirect_count [2];

   pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(RB0), .MEM_TIMEOUT(TO0)) u_dut0 (
      .clk(clk), .rst(rst), .IF_ID_type(IF_ID_type), .IF_ID_r1(IF_ID_r1), .IF_ID_r2(IF_ID_r2),
      .ID_EX_type(ID_EX_type), .ID_EX_rd(ID_EX_rd), .ex_redirect(ex_redirect),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en[0]), .IF_ID_en(IF_ID_en[0]),
      .ID_EX_en(ID_EX_en[0]), .EX_MEM_en(EX_MEM_en[0]), .IF_ID_flush(IF_ID_flush[0]),
      .ID_EX_flush(ID_EX_flush[0]), .MEM_WB_flush(MEM_WB_flush[0]), .mem_timeout(mem_timeout[0]),
      .stall_cycles(stall_cycles[0]), .redirect_count(redirect_count[0])
   );

   pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(RB1), .MEM_TIMEOUT(TO1)) u_dut1 (
      .clk(clk), .rst(rst), .IF_ID_type(IF_ID_type), .IF_ID_r1(IF_ID_r1), .IF_ID_r2(IF_ID_r2),
      .ID_EX_type(ID_EX_type), .ID_EX_rd(ID_EX_rd), .ex_redirect(ex_redirect),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en[1]), .IF_ID_en(IF_ID_en[1]),
      .ID_EX_en(ID_EX_en[1]), .EX_MEM_en(EX_MEM_en[1]), .IF_ID_flush(IF_ID_flush[1]),
      .ID_EX_flush(ID_EX_flush[1]), .MEM_WB_flush(MEM_WB_flush[1]), .mem_timeout(mem_timeout[1]),
      .stall_cycles(stall_cycles[1]), .redirect_count(redirect_count[1])
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: remaining tail bubbles, consecutive busy cycles, counters.
   int unsigned rb [2] = '{RB0, RB1};
   int unsigned to [2] = '{TO0, TO1};
   int unsigned flush_left [2];
   int unsigned busy_run [2];
   int unsigned stalls [2];
   int unsigned redirs [2];
   bit          timeout [2];
   bit [6:0]    exp_ctl [2];   // {pc,IF_ID,ID_EX,EX_MEM enables, IF_ID,ID_EX,MEM_WB flushes}
   bit          took_redir [2];
   bit          in_tail [2];

   function automatic bit model_load_use();
      bit r1_used, r2_used;
      r1_used = !(IF_ID_type inside {3'b100, 3'b101});
      r2_used = IF_ID_type inside {3'b011, 3'b010, 3'b111};
      return (ID_EX_type == 3'b000) && (ID_EX_rd != 0) &&
             ((r1_used && IF_ID_r1 == ID_EX_rd) || (r2_used && IF_ID_r2 == ID_EX_rd));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         flush_left[k] = 0;
         busy_run[k]   = 0;
         stalls[k]     = 0;
         redirs[k]     = 0;
         timeout[k]    = 0;
      end
   endtask

   task automatic step();
      bit busy;
      busy = dmem_req && !dmem_ready;
      if (rst) model_reset();
      for (int k = 0; k < 2; k++) begin
         took_redir[k] = 0;
         in_tail[k]    = 0;
         if (rst)                    exp_ctl[k] = 7'b0000_111;
         else if (busy)              exp_ctl[k] = 7'b0000_001;
         else if (flush_left[k] > 0) begin exp_ctl[k] = 7'b1111_100; in_tail[k] = 1; end
         else if (ex_redirect)       begin exp_ctl[k] = 7'b1111_110; took_redir[k] = 1; end
         else if (model_load_use())  exp_ctl[k] = 7'b0011_010;
         else                        exp_ctl[k] = 7'b1111_000;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("ctl%0d", k), {pc_en[k], IF_ID_en[k], ID_EX_en[k], EX_MEM_en[k],
               IF_ID_flush[k], ID_EX_flush[k], MEM_WB_flush[k]}, exp_ctl[k]);
         check($sformatf("timeout%0d", k), mem_timeout[k], timeout[k]);
         check($sformatf("stalls%0d", k), stall_cycles[k], stalls[k]);
         check($sformatf("redirs%0d", k), redirect_count[k], redirs[k]);
      end
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            if (busy) begin
               busy_run[k]++;
               if (busy_run[k] >= to[k]) timeout[k] = 1;
            end else begin
               busy_run[k] = 0;
            end
            if (in_tail[k]) flush_left[k]--;
            if (took_redir[k]) begin
               flush_left[k] = rb[k];
               if (redirs[k] < 65535) redirs[k]++;
            end
            if (!exp_ctl[k][6] && stalls[k] < 65535) stalls[k]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      IF_ID_type  = 3'b011;
      IF_ID_r1    = 5'd1;
      IF_ID_r2    = 5'd2;
      ID_EX_type  = 3'b001;
      ID_EX_rd    = 5'd3;
      ex_redirect = 1'b0;
      dmem_req    = 1'b0;
      dmem_ready  = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      step();

      // Load-use via r2 of an R-type consumer
      ID_EX_type = 3'b000; ID_EX_rd = 5'd5; IF_ID_type = 3'b011; IF_ID_r2 = 5'd5;
      step();
      idle_inputs();
      step();
      check("lu_stall_count", stall_cycles[0], 32'd1);

      // rd = x0, then U-type consumer with matching r1
      ID_EX_type = 3'b000; ID_EX_rd = 5'd0; IF_ID_r1 = 5'd0; IF_ID_r2 = 5'd0;
      step();
      ID_EX_rd = 5'd5; IF_ID_type = 3'b101; IF_ID_r1 = 5'd5; IF_ID_r2 = 5'd9;
      step();
      idle_inputs();

      // Redirect with its bubble tail
      ex_redirect = 1'b1;
      step();
      ex_redirect = 1'b0;
      repeat (4) step();
      check("redir_count", redirect_count[0], 32'd1);

      // Three busy cycles, no timeout
      dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (3) step();
      dmem_ready = 1'b1;
      step();
      dmem_req = 1'b0;
      step();
      check("no_timeout", mem_timeout[0], 32'd0);

      // Six busy cycles trip both timeout thresholds
      dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (6) step();
      dmem_ready = 1'b1;
      step();
      step();
      check("timeout_sticky", mem_timeout[0], 32'd1);

      // Busy during the bubble tail, then reset mid-tail
      dmem_req = 1'b0;
      ex_redirect = 1'b1;
      step();
      ex_redirect = 1'b0;
      dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (2) step();
      dmem_req = 1'b0;
      step();
      ex_redirect = 1'b1;
      step();
      ex_redirect = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) step();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 149) == 0);
         IF_ID_type  = 3'($urandom_range(0, 7));
         IF_ID_r1    = 5'($urandom_range(0, 3));
         IF_ID_r2    = 5'($urandom_range(0, 3));
         ID_EX_type  = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         ID_EX_rd    = 5'($urandom_range(0, 3));
         ex_redirect = ($urandom_range(0, 5) == 0);
         dmem_req    = ($urandom_range(0, 1) == 0);
         dmem_ready  = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
